if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction Fetch stage, directly upstream of the IF/ID pipeline register. It owns the PC and issues word fetches over a valid/ready request port to instruction memory. Memory responses arrive in order with variable latency. Returned {pc, instr} pairs are queued and presented to IF/ID, which latches them when not stalled. Branch redirects from EX flush all younger fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, max instructions (in flight + queued); power of 2, >=2
NOP_INSTR, 32'hE1A0_0000, ARM MOV r0,r0 driven when no valid instruction

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard-unit stall; IF/ID enable = ~stall
redirect_valid  in  1  branch taken / PC override from EX
redirect_pc  in  32  redirect target; bits[1:0] ignored
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response data valid (in order, one per accepted request)
imem_rsp_data  in  32  fetched instruction
valid_out  out  1  pc_out/instr_out hold a real instruction
pc_out  out  32  PC of presented instruction (to IF/ID pc_in)
instr_out  out  32  presented instruction (to IF/ID instr_in)

Behaviour:
- State:
  - fetch_pc: next address to request.
  - inflight_cnt: accepted requests with no response yet (0..DEPTH).
  - discard_cnt: in-flight responses to drop.
  - pc_q: FIFO of PCs of live in-flight requests.
  - instr_q: FIFO of returned {pc, instr}.
- Reset (sync, wins over all inputs):
  - fetch_pc=RESET_PC; all counters 0; both FIFOs empty.
  - Outputs during reset and the cycle after: imem_req_valid=0, valid_out=0, pc_out=0, instr_out=NOP_INSTR.
  - Instruction memory shares the same reset and never returns responses for pre-reset requests.
- Issue:
  - imem_req_valid = ~reset & ~redirect_valid & (inflight_cnt + instr_q.count < DEPTH).
  - imem_req_addr = fetch_pc.
  - On accept (valid & ready): push fetch_pc into pc_q; fetch_pc += 4 (mod 2^32, 0xFFFF_FFFC wraps to 0); inflight_cnt++.
  - Requests issue regardless of stall; the credit rule bounds buffering.
- Response (imem_rsp_valid):
  - inflight_cnt-- always.
  - If discard_cnt>0: discard_cnt-- and drop the data.
  - Else: pop pc_q and push {pc, data} into instr_q.
  - Simultaneous accept and response in one cycle: net inflight_cnt unchanged.
- Output:
  - valid_out = ~instr_q.empty & ~redirect_valid.
  - When valid: pc_out/instr_out = instr_q head.
  - When not valid: pc_out=0, instr_out=NOP_INSTR.
  - Head pops when valid_out & ~stall.
  - While stall=1, outputs are stable and nothing is lost; the credit rule guarantees no instr_q overflow.
  - Latency: a response arriving in cycle N is presented in cycle N+1 (1 cycle, instr_q registered).
- Redirect (priority over stall and over response enqueue):
  - In the same cycle: fetch_pc <= {redirect_pc[31:2], 2'b00}; pc_q and instr_q flushed; no request issued.
  - discard_cnt <= inflight_cnt - imem_rsp_valid (the same-cycle response is dropped).
  - First request to the target issues in the next cycle if credit allows.
  - Back-to-back redirects: the last one wins; discard_cnt is recomputed each time.
- Boundaries:
  - inflight_cnt + instr_q.count == DEPTH blocks issue.
  - Underflow (response with inflight_cnt==0) is illegal; assert in simulation.
  - A stall on an empty queue has no effect.

Decomposition:
- Shared package if_pkg: NOP_INSTR constant, ADDR_W=32, INSTR_W=32, typedef fetch_entry_t {pc, instr}.
- One sub-module, sync_fifo (WIDTH, DEPTH; push, pop, flush, empty, full, count; sync reset). Instantiated twice: pc_q (32b) and instr_q (64b).

Test Plan:
- Reset release, memory ready=1, fixed 1-cycle latency, stall=0:
  - Requests go to 0x0, 0x4, 0x8.
  - valid_out first at cycle 3 with pc_out=0x0; then one instruction per cycle in order.
- stall=1 for 5 cycles mid-stream:
  - pc_out/instr_out are held constant.
  - inflight+queued never exceeds 2; no instruction is lost or duplicated after release.
- Redirect to 0x1003 with 2 requests in flight (latency 3):
  - Both old responses are dropped.
  - Next request addr=0x1000; next valid_out has pc_out=0x1000.
- Redirect in the same cycle as a response and as stall=1:
  - Response is dropped; valid_out=0 that cycle.
  - Queue is empty the next cycle; the stall does not block the flush.
- imem_req_ready toggling randomly, latency 1-4:
  - valid_out pc sequence is exactly +4 each step.
  - fetch_pc at 0xFFFF_FFFC wraps to 0x0000_0000.
- reset asserted while 2 requests are in flight and the queue is full:
  - Next cycle valid_out=0 and imem_req_valid=0.
  - After release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction fetch stage.
//   ADDR_W        : fetch address width
//   INSTR_W       : instruction width
//   NOP_INSTR     : ARM MOV r0,r0, presented whenever no real instruction is valid
//   fetch_entry_t : one returned fetch, {pc, instr}, as held in the output queue
// -----------------------------------------------------------------------------
package if_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A0_0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small synchronous FIFO with a same-cycle flush. DEPTH must be a power of 2
// so the read/write pointers wrap on their own.
//   clk, reset : clock, synchronous active-high reset
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : empty the FIFO this cycle; overrides push/pop
//   rdata_o    : head entry (undefined when empty)
//   empty_o, full_o, count_o : occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   input  logic [WIDTH-1:0]             wdata_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic                         empty_o,
   output logic                         full_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours, independent of block order.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: storage has no reset; the pointers and count decide what is valid,
   // so clearing the array would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Owns the PC, issues word fetches to instruction memory and presents returned
// {pc, instr} pairs to the IF/ID register. A redirect from EX flushes every
// younger fetch; responses still in flight at that point are counted and
// dropped as they return.
//   clk, reset          : clock, synchronous active-high reset
//   stall               : IF/ID hold; the presented instruction is not consumed
//   redirect_valid/_pc  : PC override from EX (bits[1:0] ignored)
//   imem_req_*          : valid/ready fetch request, word-aligned address
//   imem_rsp_*          : in-order response, one per accepted request
//   valid_out/pc_out/instr_out : presented instruction (NOP_INSTR when invalid)
// -----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out
);

   import if_pkg::*;

   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  discard_q, discard_d;
   logic              after_reset_q;   // high for the first cycle out of reset

   logic              credit_ok;
   logic              req_fire;
   logic              rsp_keep;
   logic              head_pop;

   logic [ADDR_W-1:0] pc_head;
   logic              pc_empty, pc_full;
   logic [CNT_W-1:0]  pc_count;

   fetch_entry_t      iq_wdata, iq_head;
   logic              iq_empty, iq_full;
   logic [CNT_W-1:0]  iq_count;

   logic              unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Credit: requests in flight plus queued results may never exceed DEPTH, so
   // every response always finds room in the output queue, even under stall.
   assign credit_ok = ({1'b0, inflight_q} + {1'b0, iq_count}) < (CNT_W+1)'(DEPTH);

   assign imem_req_valid = ~reset & ~after_reset_q & ~redirect_valid & credit_ok;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // A response is kept only if it belongs to the current fetch stream.
   assign rsp_keep = imem_rsp_valid & (discard_q == '0) & ~redirect_valid;

   assign valid_out = ~reset & ~iq_empty & ~redirect_valid;
   assign pc_out    = valid_out ? iq_head.pc    : '0;
   assign instr_out = valid_out ? iq_head.instr : NOP_INSTR;
   assign head_pop  = valid_out & ~stall;

   assign iq_wdata = '{pc: pc_head, instr: imem_rsp_data};

   sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_q (
      .clk     (clk),
      .reset   (reset),
      .push_i  (req_fire),
      .pop_i   (rsp_keep),
      .flush_i (redirect_valid),
      .wdata_i (fetch_pc_q),
      .rdata_o (pc_head),
      .empty_o (pc_empty),
      .full_o  (pc_full),
      .count_o (pc_count)
   );

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
      .clk     (clk),
      .reset   (reset),
      .push_i  (rsp_keep),
      .pop_i   (head_pop),
      .flush_i (redirect_valid),
      .wdata_i (iq_wdata),
      .rdata_o (iq_head),
      .empty_o (iq_empty),
      .full_o  (iq_full),
      .count_o (iq_count)
   );

   // NOTE: every always_comb output gets a default first, so no path through
   // the block can leave a value unassigned and infer a latch.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      discard_d  = discard_q;

      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         // Everything still outstanding is stale, except a response returning
         // right now, which is dropped in this very cycle.
         discard_d  = inflight_q - CNT_W'(imem_rsp_valid);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (imem_rsp_valid && discard_q != '0) discard_d = discard_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= '0;
         discard_q     <= '0;
         after_reset_q <= 1'b1;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         discard_q     <= discard_d;
         after_reset_q <= 1'b0;
      end
   end

   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(imem_rsp_valid && inflight_q == '0));
   a_pc_q_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(req_fire && pc_full));
   a_pc_q_has_head: assert property (@(posedge clk) disable iff (reset)
      !(rsp_keep && pc_empty));
   a_instr_q_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(rsp_keep && iq_full && !head_pop));
   a_pc_q_tracks_live: assert property (@(posedge clk) disable iff (reset)
      ({1'b0, pc_count} + {1'b0, discard_q}) == {1'b0, inflight_q});

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'hE1A0_0000;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        valid_out;
   logic [31:0] pc_out;
   logic [31:0] instr_out;

   if_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .valid_out      (valid_out),
      .pc_out         (pc_out),
      .instr_out      (instr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory + reference model. Each outstanding request carries the epoch
   // (redirect generation) it was issued in; stale epochs never reach IF/ID.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mem_entry_t;

   mem_entry_t  mem_q[$];
   logic [31:0] iq[$];
   int          epoch, cyc, last_due, lat_min, lat_max;
   logic [31:0] m_fetch;
   bit          rst_prev;

   logic        o_req_valid, o_valid, o_rsp;
   logic [31:0] o_req_addr, o_pc, o_instr;
   logic        e_req_valid, e_valid;
   logic [31:0] e_req_addr, e_pc, e_instr;

   int checks, failures;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a ^ 32'h5A5A_1234) + {a[24:0], 7'h0};
   endfunction

   task automatic step(input bit rst, input bit stl, input bit redir,
                       input logic [31:0] rpc, input bit rdy);
      mem_entry_t e;
      bit keep;
      int lat;
      reset          = rst;
      stall          = stl;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_req_ready = rdy;
      if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_data(mem_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);
      o_req_valid = imem_req_valid;
      o_req_addr  = imem_req_addr;
      o_valid     = valid_out;
      o_pc        = pc_out;
      o_instr     = instr_out;
      o_rsp       = imem_rsp_valid;
      e_valid     = !rst && !redir && iq.size() > 0;
      e_pc        = e_valid ? iq[0] : 32'h0;
      e_instr     = e_valid ? mem_data(iq[0]) : NOP;
      e_req_valid = !rst && !rst_prev && !redir && (mem_q.size() + iq.size() < DEPTH);
      e_req_addr  = m_fetch;
      if (rst) begin
         mem_q.delete();
         iq.delete();
         m_fetch  = RESET_PC;
         epoch++;
         rst_prev = 1'b1;
         last_due = cyc;
      end else begin
         keep = 1'b0;
         if (o_rsp) begin
            e = mem_q.pop_front();
            keep = !redir && (e.epoch == epoch);
         end
         if (e_valid && !stl) void'(iq.pop_front());
         if (keep) iq.push_back(e.pc);
         if (redir) begin
            iq.delete();
            m_fetch = {rpc[31:2], 2'b00};
            epoch++;
         end else if (o_req_valid && rdy) begin
            lat = $urandom_range(lat_max, lat_min);
            e.pc    = m_fetch;
            e.addr  = o_req_addr;
            e.epoch = epoch;
            e.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = e.due;
            mem_q.push_back(e);
            m_fetch = m_fetch + 32'd4;
         end
         rst_prev = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      checks += 4;
      if (o_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b want 0", o_req_valid); end
      if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_out: got %b want 0", o_valid); end
      if (o_pc !== 32'h0) begin failures++; $display("FAIL reset_pc_out: got %h want 0", o_pc); end
      if (o_instr !== NOP) begin failures++; $display("FAIL reset_instr_out: got %h want %h", o_instr, NOP); end
      step(0, 0, 0, 0, 1);
      checks += 2;
      if (o_req_valid !== 1'b0) begin failures++; $display("FAIL post_reset_req_valid: got %b want 0", o_req_valid); end
      if (o_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid_out: got %b want 0", o_valid); end
   endtask

   task automatic test_basic();
      logic [31:0] addrs[3];
      int n_addr, first_t, n_cons;
      lat_min = 1; lat_max = 1;
      n_addr = 0; first_t = -1; n_cons = 0;
      step(1, 0, 0, 0, 1);
      for (int t = 0; t < 20; t++) begin
         step(0, 0, 0, 0, 1);
         if (o_req_valid && n_addr < 3) begin addrs[n_addr] = o_req_addr; n_addr++; end
         checks += 2;
         if (o_req_valid !== e_req_valid) begin failures++; $display("FAIL basic_req_valid t=%0d: got %b want %b", t, o_req_valid, e_req_valid); end
         if (o_valid !== e_valid) begin failures++; $display("FAIL basic_valid t=%0d: got %b want %b", t, o_valid, e_valid); end
         if (o_valid) begin
            if (first_t < 0) first_t = t;
            checks += 2;
            if (o_pc !== 32'(n_cons * 4)) begin failures++; $display("FAIL basic_pc t=%0d: got %h want %h", t, o_pc, 32'(n_cons * 4)); end
            if (o_instr !== mem_data(32'(n_cons * 4))) begin failures++; $display("FAIL basic_instr t=%0d: got %h want %h", t, o_instr, mem_data(32'(n_cons * 4))); end
            n_cons++;
         end
      end
      checks += 4;
      if (n_addr !== 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
         failures++; $display("FAIL basic_req_addrs: got n=%0d %h %h %h want 0 4 8", n_addr, addrs[0], addrs[1], addrs[2]);
      end
      if (first_t !== 3) begin failures++; $display("FAIL basic_first_valid_cycle: got %0d want 3", first_t); end
      if (n_cons < 5) begin failures++; $display("FAIL basic_throughput: got %0d want >=5", n_cons); end
      if (e_pc !== o_pc) begin failures++; $display("FAIL basic_model_pc: got %h want %h", o_pc, e_pc); end
   endtask

   task automatic test_stall();
      logic [31:0] hold_pc, hold_instr, next_pc;
      int waited, n_cons;
      lat_min = 1; lat_max = 1;
      waited = 0;
      step(0, 1, 0, 0, 1);
      while (!o_valid && waited < 10) begin step(0, 1, 0, 0, 1); waited++; end
      hold_pc = o_pc; hold_instr = o_instr;
      checks++;
      if (!o_valid) begin failures++; $display("FAIL stall_timeout: got valid %b want 1", o_valid); end
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0, 1);
         checks += 4;
         if (o_valid !== 1'b1) begin failures++; $display("FAIL stall_valid i=%0d: got %b want 1", i, o_valid); end
         if (o_pc !== hold_pc) begin failures++; $display("FAIL stall_pc_hold i=%0d: got %h want %h", i, o_pc, hold_pc); end
         if (o_instr !== hold_instr) begin failures++; $display("FAIL stall_instr_hold i=%0d: got %h want %h", i, o_instr, hold_instr); end
         if (o_req_valid !== e_req_valid || mem_q.size() > DEPTH) begin
            failures++; $display("FAIL stall_credit i=%0d: got req %b outstanding %0d want req %b", i, o_req_valid, mem_q.size(), e_req_valid);
         end
      end
      next_pc = hold_pc; n_cons = 0; waited = 0;
      while (n_cons < 4 && waited < 30) begin
         step(0, 0, 0, 0, 1);
         waited++;
         if (o_valid) begin
            checks++;
            if (o_pc !== next_pc) begin failures++; $display("FAIL stall_release_pc: got %h want %h", o_pc, next_pc); end
            next_pc = next_pc + 32'd4; n_cons++;
         end
      end
      checks++;
      if (n_cons < 4) begin failures++; $display("FAIL stall_release_timeout: got %0d want 4", n_cons); end
   endtask

   task automatic test_redirect();
      int waited;
      lat_min = 3; lat_max = 3;
      waited = 0;
      while (mem_q.size() != 2 && waited < 20) begin step(0, 0, 0, 0, 1); waited++; end
      checks++;
      if (mem_q.size() != 2) begin failures++; $display("FAIL redirect_setup: got %0d in flight want 2", mem_q.size()); end
      step(0, 0, 1, 32'h1003, 1);
      checks += 2;
      if (o_req_valid !== 1'b0) begin failures++; $display("FAIL redirect_req_valid: got %b want 0", o_req_valid); end
      if (o_valid !== 1'b0) begin failures++; $display("FAIL redirect_valid_out: got %b want 0", o_valid); end
      waited = 0;
      step(0, 0, 0, 0, 1);
      while (!o_req_valid && waited < 20) begin step(0, 0, 0, 0, 1); waited++; end
      checks++;
      if (o_req_valid !== 1'b1 || o_req_addr !== 32'h1000) begin
         failures++; $display("FAIL redirect_req_addr: got %b/%h want 1/00001000", o_req_valid, o_req_addr);
      end
      waited = 0;
      while (!o_valid && waited < 20) begin step(0, 0, 0, 0, 1); waited++; end
      checks += 2;
      if (o_valid !== 1'b1 || o_pc !== 32'h1000) begin failures++; $display("FAIL redirect_first_pc: got %b/%h want 1/00001000", o_valid, o_pc); end
      if (o_instr !== mem_data(32'h1000)) begin failures++; $display("FAIL redirect_first_instr: got %h want %h", o_instr, mem_data(32'h1000)); end
   endtask

   task automatic test_redirect_rsp_stall();
      int waited;
      lat_min = 1; lat_max = 1;
      waited = 0;
      while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && waited < 20) begin step(0, 0, 0, 0, 1); waited++; end
      step(0, 1, 1, 32'h2000, 1);
      checks += 2;
      if (o_rsp !== 1'b1) begin failures++; $display("FAIL rsp_stall_setup: got rsp %b want 1", o_rsp); end
      if (o_valid !== 1'b0) begin failures++; $display("FAIL rsp_stall_valid_out: got %b want 0", o_valid); end
      step(0, 1, 0, 0, 1);
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL rsp_stall_flushed: got %b want 0", o_valid); end
      waited = 0;
      while (!o_valid && waited < 20) begin step(0, 0, 0, 0, 1); waited++; end
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h2000) begin failures++; $display("FAIL rsp_stall_first_pc: got %b/%h want 1/00002000", o_valid, o_pc); end
   endtask

   task automatic test_wrap();
      logic [31:0] want[3];
      int n_req, n_cons, waited;
      want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
      lat_min = 1; lat_max = 1;
      n_req = 0; n_cons = 0; waited = 0;
      step(0, 0, 1, 32'hFFFF_FFFA, 1);
      while ((n_req < 3 || n_cons < 3) && waited < 40) begin
         step(0, 0, 0, 0, 1);
         waited++;
         if (o_req_valid && n_req < 3) begin
            checks++;
            if (o_req_addr !== want[n_req]) begin failures++; $display("FAIL wrap_req_addr %0d: got %h want %h", n_req, o_req_addr, want[n_req]); end
            n_req++;
         end
         if (o_valid && n_cons < 3) begin
            checks++;
            if (o_pc !== want[n_cons]) begin failures++; $display("FAIL wrap_pc %0d: got %h want %h", n_cons, o_pc, want[n_cons]); end
            n_cons++;
         end
      end
      checks++;
      if (n_req < 3 || n_cons < 3) begin failures++; $display("FAIL wrap_timeout: got req %0d cons %0d want 3 3", n_req, n_cons); end
   endtask

   task automatic test_random();
      bit stl, redir, rdy, have_last;
      logic [31:0] rpc, last_pc;
      lat_min = 1; lat_max = 4;
      have_last = 1'b0; last_pc = 0;
      for (int i = 0; i < 800; i++) begin
         rdy   = ($urandom % 4) != 0;
         stl   = ($urandom % 4) == 0;
         redir = ($urandom % 32) == 0;
         rpc   = ($urandom % 2) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
         step(0, stl, redir, rpc, rdy);
         checks += 3;
         if (o_req_valid !== e_req_valid) begin failures++; $display("FAIL rand_req_valid i=%0d: got %b want %b", i, o_req_valid, e_req_valid); end
         if (o_valid !== e_valid || o_pc !== e_pc) begin failures++; $display("FAIL rand_out i=%0d: got %b/%h want %b/%h", i, o_valid, o_pc, e_valid, e_pc); end
         if (o_instr !== e_instr) begin failures++; $display("FAIL rand_instr i=%0d: got %h want %h", i, o_instr, e_instr); end
         if (e_req_valid && o_req_valid) begin
            checks++;
            if (o_req_addr !== e_req_addr) begin failures++; $display("FAIL rand_req_addr i=%0d: got %h want %h", i, o_req_addr, e_req_addr); end
         end
         if (redir) have_last = 1'b0;
         if (o_valid && !stl) begin
            if (have_last) begin
               checks++;
               if (o_pc !== last_pc + 32'd4) begin failures++; $display("FAIL rand_pc_step i=%0d: got %h want %h", i, o_pc, last_pc + 32'd4); end
            end
            last_pc = o_pc; have_last = 1'b1;
         end
      end
   endtask

   task automatic test_reset_midflight();
      int waited;
      lat_min = 3; lat_max = 3;
      waited = 0;
      while (!(mem_q.size() >= 1 && mem_q.size() + iq.size() == DEPTH) && waited < 30) begin
         step(0, 1, 0, 0, 1); waited++;
      end
      checks++;
      if (mem_q.size() + iq.size() != DEPTH) begin failures++; $display("FAIL midreset_setup: got %0d want %0d", mem_q.size() + iq.size(), DEPTH); end
      step(1, 1, 0, 0, 1);
      checks += 2;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid_out: got %b want 0", o_valid); end
      if (o_req_valid !== 1'b0) begin failures++; $display("FAIL midreset_req_valid: got %b want 0", o_req_valid); end
      step(0, 0, 0, 0, 1);
      checks += 2;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL midreset_next_valid_out: got %b want 0", o_valid); end
      if (o_req_valid !== 1'b0) begin failures++; $display("FAIL midreset_next_req_valid: got %b want 0", o_req_valid); end
      waited = 0;
      step(0, 0, 0, 0, 1);
      while (!o_req_valid && waited < 10) begin step(0, 0, 0, 0, 1); waited++; end
      checks++;
      if (o_req_valid !== 1'b1 || o_req_addr !== RESET_PC) begin failures++; $display("FAIL midreset_restart_addr: got %b/%h want 1/%h", o_req_valid, o_req_addr, RESET_PC); end
      waited = 0;
      while (!o_valid && waited < 20) begin step(0, 0, 0, 0, 1); waited++; end
      checks++;
      if (o_valid !== 1'b1 || o_pc !== RESET_PC) begin failures++; $display("FAIL midreset_restart_pc: got %b/%h want 1/%h", o_valid, o_pc, RESET_PC); end
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0; epoch = 0; last_due = 0;
      lat_min = 1; lat_max = 1; m_fetch = RESET_PC; rst_prev = 1'b0;
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_redirect_rsp_stall();
      test_wrap();
      test_random();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
